// File: rtl/loot_spawner_if.sv
// rtl/loot_spawner_if.sv - Player, pixel and collect signals of the loot spawner
interface loot_spawner_if;
  logic       SpawnEnable;
  logic [9:0] P1X, P1Y, P2X, P2Y;
  logic       P1Full, P2Full, P1Dead, P2Dead;
  logic [9:0] DrawX, DrawY;
  logic [1:0] P1Collect, P2Collect;
  logic       LootPixel;
  logic [1:0] LootValue;
  logic [3:0] LootPixX, LootPixY;
  logic [3:0] ActiveCount;

  modport master (
    output SpawnEnable, P1X, P1Y, P2X, P2Y, P1Full, P2Full, P1Dead, P2Dead,
    output DrawX, DrawY,
    input  P1Collect, P2Collect, LootPixel, LootValue, LootPixX, LootPixY, ActiveCount
  );

  modport slave (
    input  SpawnEnable, P1X, P1Y, P2X, P2Y, P1Full, P2Full, P1Dead, P2Dead,
    input  DrawX, DrawY,
    output P1Collect, P2Collect, LootPixel, LootValue, LootPixX, LootPixY, ActiveCount
  );
endinterface

// File: rtl/loot_spawner.sv
// rtl/loot_spawner.sv - Loot slot spawning, pickup arbitration and pixel lookup
module loot_spawner #(
  parameter int          NUM_SLOTS      = 4,
  parameter int          RESPAWN_FRAMES = 120,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1,
  parameter int          ITEM_SIZE      = 16
) (
  input logic           FrameClk,
  input logic           ResetN,
  loot_spawner_if.slave bus
);
  typedef enum logic {ST_COOLDOWN = 1'b0, ST_ACTIVE = 1'b1} slot_state_e;

  localparam logic [7:0]  RESPAWN   = 8'(RESPAWN_FRAMES);
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [10:0] ITEM_W    = 11'(ITEM_SIZE);

  slot_state_e state_q [NUM_SLOTS];
  slot_state_e state_d [NUM_SLOTS];
  logic [9:0]  x_q     [NUM_SLOTS];
  logic [9:0]  x_d     [NUM_SLOTS];
  logic [9:0]  y_q     [NUM_SLOTS];
  logic [9:0]  y_d     [NUM_SLOTS];
  logic [1:0]  val_q   [NUM_SLOTS];
  logic [1:0]  val_d   [NUM_SLOTS];
  logic [7:0]  cnt_q   [NUM_SLOTS];
  logic [7:0]  cnt_d   [NUM_SLOTS];

  logic [15:0] lfsr_q, lfsr_d;
  logic [1:0]  p1_collect_q, p1_collect_d;
  logic [1:0]  p2_collect_q, p2_collect_d;
  logic [3:0]  active_count_q, active_count_d;

  logic [NUM_SLOTS-1:0] p1_take, p2_take, spawn_sel;
  logic                 p1_ok, p2_ok, p1_found, p2_found, sp_found;
  logic [9:0]           spawn_x, spawn_y;
  logic [1:0]           spawn_val;

  logic       pix_hit;
  logic [1:0] pix_val;
  logic [3:0] pix_x, pix_y;

  // Player hitbox is 32x32, item is ITEM_SIZE square; touching edges do not count
  function automatic logic overlaps(input logic [9:0] px, input logic [9:0] py,
                                    input logic [9:0] ix, input logic [9:0] iy);
    return ({1'b0, px} < {1'b0, ix} + ITEM_W) && ({1'b0, ix} < {1'b0, px} + 11'd32) &&
           ({1'b0, py} < {1'b0, iy} + ITEM_W) && ({1'b0, iy} < {1'b0, py} + 11'd32);
  endfunction

  assign p1_ok     = !bus.P1Full && !bus.P1Dead;
  assign p2_ok     = !bus.P2Full && !bus.P2Dead;
  assign spawn_x   = 10'd128 + {1'b0, lfsr_q[8:0]};
  assign spawn_y   = 10'd112 + {2'b00, lfsr_q[14:9], 2'b00};
  assign spawn_val = (lfsr_q[15:14] == 2'b00) ? 2'd1 : lfsr_q[15:14];

  // P1 has priority on a shared slot; P2 falls through to its next overlapping slot
  always_comb begin
    p1_take   = '0;
    p2_take   = '0;
    spawn_sel = '0;
    p1_found  = 1'b0;
    p2_found  = 1'b0;
    sp_found  = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (state_q[i] == ST_ACTIVE) begin
        if (!p1_found && p1_ok && overlaps(bus.P1X, bus.P1Y, x_q[i], y_q[i])) begin
          p1_take[i] = 1'b1;
          p1_found   = 1'b1;
        end else if (!p2_found && p2_ok && overlaps(bus.P2X, bus.P2Y, x_q[i], y_q[i])) begin
          p2_take[i] = 1'b1;
          p2_found   = 1'b1;
        end
      end else if (!sp_found && cnt_q[i] == 8'd0) begin
        spawn_sel[i] = 1'b1;
        sp_found     = 1'b1;
      end
    end
  end

  always_comb begin
    lfsr_d         = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    p1_collect_d   = '0;
    p2_collect_d   = '0;
    active_count_d = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      state_d[i] = state_q[i];
      x_d[i]     = x_q[i];
      y_d[i]     = y_q[i];
      val_d[i]   = val_q[i];
      cnt_d[i]   = cnt_q[i];
      if (!bus.SpawnEnable) begin
        state_d[i] = ST_COOLDOWN;
        cnt_d[i]   = RESPAWN;
      end else if (p1_take[i] || p2_take[i]) begin
        state_d[i] = ST_COOLDOWN;
        cnt_d[i]   = RESPAWN;
        if (p1_take[i]) p1_collect_d = val_q[i];
        if (p2_take[i]) p2_collect_d = val_q[i];
      end else if (spawn_sel[i]) begin
        state_d[i] = ST_ACTIVE;
        x_d[i]     = spawn_x;
        y_d[i]     = spawn_y;
        val_d[i]   = spawn_val;
      end else if (state_q[i] == ST_COOLDOWN && cnt_q[i] != 8'd0) begin
        cnt_d[i] = cnt_q[i] - 8'd1;
      end
      if (state_d[i] == ST_ACTIVE) active_count_d = active_count_d + 4'd1;
    end
  end

  always_comb begin
    pix_hit = 1'b0;
    pix_val = '0;
    pix_x   = '0;
    pix_y   = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!pix_hit && state_q[i] == ST_ACTIVE &&
          bus.DrawX >= x_q[i] && {1'b0, bus.DrawX} < {1'b0, x_q[i]} + ITEM_W &&
          bus.DrawY >= y_q[i] && {1'b0, bus.DrawY} < {1'b0, y_q[i]} + ITEM_W) begin
        pix_hit = 1'b1;
        pix_val = val_q[i];
        pix_x   = bus.DrawX[3:0] - x_q[i][3:0];
        pix_y   = bus.DrawY[3:0] - y_q[i][3:0];
      end
    end
  end

  always_ff @(posedge FrameClk or negedge ResetN) begin
    if (!ResetN) begin
      lfsr_q         <= LFSR_SEED;
      p1_collect_q   <= '0;
      p2_collect_q   <= '0;
      active_count_q <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        state_q[i] <= ST_COOLDOWN;
        x_q[i]     <= '0;
        y_q[i]     <= '0;
        val_q[i]   <= '0;
        cnt_q[i]   <= RESPAWN;
      end
    end else begin
      lfsr_q         <= lfsr_d;
      p1_collect_q   <= p1_collect_d;
      p2_collect_q   <= p2_collect_d;
      active_count_q <= active_count_d;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        state_q[i] <= state_d[i];
        x_q[i]     <= x_d[i];
        y_q[i]     <= y_d[i];
        val_q[i]   <= val_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign bus.P1Collect   = p1_collect_q;
  assign bus.P2Collect   = p2_collect_q;
  assign bus.ActiveCount = active_count_q;
  assign bus.LootPixel   = pix_hit;
  assign bus.LootValue   = pix_val;
  assign bus.LootPixX    = pix_x;
  assign bus.LootPixY    = pix_y;
endmodule

// File: tb/tb_loot_spawner.sv
// tb/tb_loot_spawner.sv - Random and directed checks of loot_spawner against a frame model
module tb_loot_spawner;
  localparam int NS      = 4;
  localparam int RESPAWN = 120;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  int m_act [NS];
  int m_x   [NS];
  int m_y   [NS];
  int m_val [NS];
  int m_cnt [NS];
  int m_lfsr, m_c1, m_c2, m_ac;

  loot_spawner_if bus();

  loot_spawner #(
    .NUM_SLOTS(NS), .RESPAWN_FRAMES(RESPAWN), .LFSR_SEED(16'hACE1), .ITEM_SIZE(16)
  ) dut (
    .FrameClk(clk),
    .ResetN  (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic bit hits(input int px, input int py, input int ix, input int iy);
    return (px < ix + 16) && (ix < px + 32) && (py < iy + 16) && (iy < py + 32);
  endfunction

  task automatic model_reset();
    m_lfsr = 'hACE1;
    m_c1 = 0; m_c2 = 0; m_ac = 0;
    for (int i = 0; i < NS; i++) begin
      m_act[i] = 0; m_x[i] = 0; m_y[i] = 0; m_val[i] = 0; m_cnt[i] = RESPAWN;
    end
  endtask

  // One frame of the game rules, evaluated from the inputs present before the edge
  task automatic model_frame();
    int t1, t2, sp;
    t1 = -1; t2 = -1; sp = -1;
    m_c1 = 0; m_c2 = 0;
    if (!bus.SpawnEnable) begin
      for (int i = 0; i < NS; i++) begin m_act[i] = 0; m_cnt[i] = RESPAWN; end
    end else begin
      if (!bus.P1Full && !bus.P1Dead)
        for (int i = 0; i < NS; i++)
          if (t1 < 0 && m_act[i] != 0 && hits(int'(bus.P1X), int'(bus.P1Y), m_x[i], m_y[i])) t1 = i;
      if (!bus.P2Full && !bus.P2Dead)
        for (int i = 0; i < NS; i++)
          if (t2 < 0 && i != t1 && m_act[i] != 0 && hits(int'(bus.P2X), int'(bus.P2Y), m_x[i], m_y[i])) t2 = i;
      for (int i = 0; i < NS; i++)
        if (sp < 0 && m_act[i] == 0 && m_cnt[i] == 0) sp = i;
      if (t1 >= 0) m_c1 = m_val[t1];
      if (t2 >= 0) m_c2 = m_val[t2];
      for (int i = 0; i < NS; i++) begin
        if (i == t1 || i == t2) begin
          m_act[i] = 0; m_cnt[i] = RESPAWN;
        end else if (i == sp) begin
          m_act[i] = 1;
          m_x[i]   = 128 + (m_lfsr % 512);
          m_y[i]   = 112 + 4 * ((m_lfsr / 512) % 64);
          m_val[i] = (m_lfsr / 16384) % 4;
          if (m_val[i] == 0) m_val[i] = 1;
        end else if (m_act[i] == 0 && m_cnt[i] > 0) begin
          m_cnt[i]--;
        end
      end
    end
    if (m_lfsr % 2 == 1) m_lfsr = (m_lfsr / 2) ^ 'hB400;
    else m_lfsr = m_lfsr / 2;
    m_ac = 0;
    for (int i = 0; i < NS; i++) m_ac += m_act[i];
  endtask

  task automatic frame(input string tag);
    model_frame();
    @(posedge clk);
    #1;
    chk({tag, "_p1c"}, int'(bus.P1Collect), m_c1);
    chk({tag, "_p2c"}, int'(bus.P2Collect), m_c2);
    chk({tag, "_ac"}, int'(bus.ActiveCount), m_ac);
  endtask

  task automatic pix_check(input string tag, input int dx, input int dy);
    int hit, v, ox, oy;
    hit = 0; v = 0; ox = 0; oy = 0;
    bus.DrawX = 10'(dx);
    bus.DrawY = 10'(dy);
    #1;
    for (int i = 0; i < NS; i++)
      if (hit == 0 && m_act[i] != 0 && dx >= m_x[i] && dx < m_x[i] + 16 &&
          dy >= m_y[i] && dy < m_y[i] + 16) begin
        hit = 1; v = m_val[i]; ox = dx - m_x[i]; oy = dy - m_y[i];
      end
    chk({tag, "_pix"}, int'(bus.LootPixel), hit);
    chk({tag, "_val"}, int'(bus.LootValue), v);
    chk({tag, "_ox"}, int'(bus.LootPixX), ox);
    chk({tag, "_oy"}, int'(bus.LootPixY), oy);
  endtask

  function automatic int near(input int c);
    int t;
    case ($urandom_range(0, 3))
      0: t = c - 32;
      1: t = c - 31;
      2: t = c + 15;
      default: t = c + int'($urandom_range(0, 47)) - 32;
    endcase
    return (t < 0) ? 0 : t;
  endfunction

  function automatic int first_active();
    for (int i = 0; i < NS; i++) if (m_act[i] != 0) return i;
    return 0;
  endfunction

  task automatic players_far();
    bus.P1X = 10'd0; bus.P1Y = 10'd0; bus.P2X = 10'd0; bus.P2Y = 10'd0;
    bus.P1Full = 1'b0; bus.P2Full = 1'b0; bus.P1Dead = 1'b0; bus.P2Dead = 1'b0;
  endtask

  initial begin
    int k;
    bus.SpawnEnable = 1'b1;
    bus.DrawX = 10'd0;
    bus.DrawY = 10'd0;
    players_far();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_p1c", int'(bus.P1Collect), 0);
    chk("rst_p2c", int'(bus.P2Collect), 0);
    chk("rst_ac", int'(bus.ActiveCount), 0);
    chk("rst_pix", int'(bus.LootPixel), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int f = 0; f < RESPAWN; f++) frame("idle");
    chk("idle_end_ac", int'(bus.ActiveCount), 0);
    for (int s = 1; s <= NS; s++) begin
      frame("ramp");
      chk("ramp_step_ac", int'(bus.ActiveCount), s);
    end

    // Adjacency: player right edge touching item left edge, then one pixel into it
    k = first_active();
    bus.P1Y = 10'(m_y[k]);
    bus.P1X = 10'(m_x[k] - 32);
    frame("adj_touch");
    k = first_active();
    bus.P1Y = 10'(m_y[k]);
    bus.P1X = 10'(m_x[k] - 31);
    frame("adj_in");
    players_far();
    frame("adj_after");

    k = first_active();
    pix_check("pix_corner", m_x[k] + 15, m_y[k] + 15);
    pix_check("pix_right", m_x[k] + 16, m_y[k] + 15);
    pix_check("pix_origin", m_x[k], m_y[k]);

    k = first_active();
    bus.P1X = 10'(m_x[k] - 10); bus.P1Y = 10'(m_y[k] - 10); bus.P1Full = 1'b1;
    bus.P2X = 10'(m_x[k] - 10); bus.P2Y = 10'(m_y[k] - 10);
    frame("p1full");
    players_far();
    k = first_active();
    bus.P1X = 10'(m_x[k] - 5); bus.P1Y = 10'(m_y[k] - 5);
    bus.P2X = 10'(m_x[k] - 5); bus.P2Y = 10'(m_y[k] - 5);
    frame("both");
    bus.SpawnEnable = 1'b0;
    frame("drop");
    chk("drop_clear_ac", int'(bus.ActiveCount), 0);
    bus.SpawnEnable = 1'b1;
    players_far();

    for (int f = 0; f < 1600; f++) begin
      int a, b;
      a = int'($urandom_range(0, NS - 1));
      b = int'($urandom_range(0, NS - 1));
      bus.SpawnEnable = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 3) == 0) begin
        bus.P1X = 10'($urandom_range(0, 1023)); bus.P1Y = 10'($urandom_range(0, 1023));
      end else begin
        bus.P1X = 10'(near(m_x[a])); bus.P1Y = 10'(near(m_y[a]));
      end
      if ($urandom_range(0, 2) == 0) begin
        bus.P2X = bus.P1X; bus.P2Y = bus.P1Y;
      end else begin
        bus.P2X = 10'(near(m_x[b])); bus.P2Y = 10'(near(m_y[b]));
      end
      bus.P1Full = ($urandom_range(0, 4) == 0);
      bus.P2Full = ($urandom_range(0, 4) == 0);
      bus.P1Dead = ($urandom_range(0, 4) == 0);
      bus.P2Dead = ($urandom_range(0, 4) == 0);
      frame("rnd");
      if (f % 4 == 0) begin
        pix_check("rnd_near", m_x[a] + int'($urandom_range(0, 19)) - 2,
                  m_y[a] + int'($urandom_range(0, 19)) - 2);
        pix_check("rnd_any", int'($urandom_range(100, 700)), int'($urandom_range(100, 400)));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
